// File: rtl/mac_accumulator.sv
// Multiply-accumulate stage: a 4x4 tree multiplier feeds a product register, whose values
// are summed per frame (closed by in_last) with saturation and handed out over valid/ready.

module main (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] o
);

  logic [7:0] r0, r1, r2, r3;
  logic [7:0] s1, c1, s2, c2;
  logic [7:0] g0, p0, g1, p1, g2, p2, g3;

  always_comb begin
    r0 = {4'b0000, x & {4{y[0]}}};
    r1 = {3'b000, x & {4{y[1]}}, 1'b0};
    r2 = {2'b00, x & {4{y[2]}}, 2'b00};
    r3 = {1'b0, x & {4{y[3]}}, 3'b000};

    // Two carry-save levels compress the four partial-product rows into a sum/carry pair.
    // The product never exceeds 225, so nothing is lost by dropping carries past bit 7.
    s1 = r0 ^ r1 ^ r2;
    c1 = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;
    s2 = s1 ^ c1 ^ r3;
    c2 = ((s1 & c1) | (s1 & r3) | (c1 & r3)) << 1;

    // Kogge-Stone prefix adder resolves the final sum/carry pair.
    g0 = s2 & c2;
    p0 = s2 ^ c2;
    g1 = g0;
    p1 = p0;
    for (int i = 1; i < 8; i++) begin
      g1[i] = g0[i] | (p0[i] & g0[i-1]);
      p1[i] = p0[i] & p0[i-1];
    end
    g2 = g1;
    p2 = p1;
    for (int i = 2; i < 8; i++) begin
      g2[i] = g1[i] | (p1[i] & g1[i-2]);
      p2[i] = p1[i] & p1[i-2];
    end
    g3 = g2;
    for (int i = 4; i < 8; i++) begin
      g3[i] = g2[i] | (p2[i] & g2[i-4]);
    end
    o = p0 ^ {g3[6:0], 1'b0};
  end

endmodule

module mac_accumulator #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       x,
  input  logic [3:0]       y,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] out_count,
  output logic             overflow
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // the sender holds data stable while valid && !ready, and valid never waits on ready.
  typedef enum logic {S_IDLE, S_VALID} res_state_t;

  res_state_t       state_q, state_d;
  logic [7:0]       prod, prod_q;
  logic             pv_q, last_q;
  logic [ACC_W-1:0] acc, sat_sum;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             ovf, carry;
  logic [ACC_W:0]   sum;
  logic             consume, accept, last_consume;

  main u_mult (
    .x(x),
    .y(y),
    .o(prod)
  );

  // A last product may only retire when the result slot is free or being emptied this cycle.
  assign consume      = pv_q && !(last_q && out_valid && !out_ready);
  assign last_consume = consume && last_q;
  assign in_ready     = !rst && (!pv_q || consume);
  assign accept       = in_valid && in_ready;

  assign sum     = {1'b0, acc} + {{(ACC_W-7){1'b0}}, prod_q};
  assign carry   = sum[ACC_W];
  assign sat_sum = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      last_q <= 1'b0;
      pv_q   <= 1'b0;
    end else if (accept) begin
      prod_q <= prod;
      last_q <= in_last;
      pv_q   <= 1'b1;
    end else if (consume) begin
      pv_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (consume) begin
      if (last_q) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        acc <= sat_sum;
        cnt <= cnt_inc;
        ovf <= ovf | carry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_out   <= '0;
      out_count <= '0;
      overflow  <= 1'b0;
    end else if (last_consume) begin
      acc_out   <= sat_sum;
      out_count <= cnt_inc;
      overflow  <= ovf | carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (last_consume) state_d = S_VALID;
      S_VALID: if (!last_consume && out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == S_VALID);
  end

endmodule
